// File: rtl/fosfor_present_hostif.sv
`default_nettype none
// ============================================================================
// Module   : fosfor_present_hostif
// Purpose  : Nibble-bus host interface for a PRESENT core. Provides register
//            address auto-increment, a busy lockout with a sticky error
//            flag, a ciphertext snapshot and an 8-bit completion counter.
// Ports    : Clk_ik        - system clock (rising edge)
//            Reset_ir      - synchronous active-high reset
//            Addr_ib[1:0]  - 00 status, 01 command, 10 data lo, 11 data hi
//            Data_ib[3:0]  - write nibble
//            Data_ob[7:0]  - read data (Addr_ib[1]=1) or status
//            PlainText_ob  - plaintext to the core
//            Key_ob        - key to the core
//            CipherText_ib - ciphertext from the core
//            Start_o       - start request to the core
//            Ready_i       - core ready
// Revision : 1.0 - initial release
// ============================================================================
module fosfor_present_hostif #(
  parameter int unsigned KEY_W       = 80,
  parameter int unsigned AUTO_INC    = 1,
  parameter int unsigned TEST_REG_EN = 1
) (
  input  logic             Clk_ik,
  input  logic             Reset_ir,
  input  logic [1:0]       Addr_ib,
  input  logic [3:0]       Data_ib,
  output logic [7:0]       Data_ob,
  output logic [63:0]      PlainText_ob,
  output logic [KEY_W-1:0] Key_ob,
  input  logic [63:0]      CipherText_ib,
  output logic             Start_o,
  input  logic             Ready_i
);

  localparam int        KB   = KEY_W / 8;
  localparam logic [4:0] KB_L = 5'(KB);

  localparam int CMD_LATCH = 0;
  localparam int CMD_ADV   = 1;
  localparam int CMD_WRITE = 2;
  localparam int CMD_START = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_CAP  = 2'd3;

  logic [3:0]       cmd_q,   cmd_d;
  logic [7:0]       in_q,    in_d;
  logic [7:0]       addr_q,  addr_d;
  logic [63:0]      pt_q,    pt_d;
  logic [KEY_W-1:0] key_q,   key_d;
  logic [7:0]       test_q,  test_d;
  logic [63:0]      snap_q,  snap_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic             done_q,  done_d;
  logic             err_q,   err_d;
  logic [1:0]       state_q, state_d;

  logic       w_busy;
  logic       w_pt_hit;
  logic       w_key_hit;
  logic       w_test_hit;
  logic [7:0] w_rd_data;
  logic [7:0] w_status;

  assign w_busy     = (state_q != S_IDLE);
  assign w_pt_hit   = (addr_q[7:3] == 5'd0);
  assign w_key_hit  = (addr_q[7:4] == 4'h1) && ({1'b0, addr_q[3:0]} < KB_L);
  assign w_test_hit = (addr_q == 8'h08) && (TEST_REG_EN != 0);

  always_comb begin
    cmd_d   = (Addr_ib == 2'b01) ? Data_ib : 4'h0;
    in_d    = in_q;
    if (Addr_ib == 2'b10) in_d[3:0] = Data_ib;
    if (Addr_ib == 2'b11) in_d[7:4] = Data_ib;

    addr_d  = addr_q;
    pt_d    = pt_q;
    key_d   = key_q;
    test_d  = test_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    state_d = state_q;

    // LATCH wins over auto-increment; a combined WRITE still targets addr_q.
    if (cmd_q[CMD_LATCH]) begin
      addr_d = in_q;
      err_d  = 1'b0;
    end else if ((AUTO_INC != 0) && (cmd_q[CMD_WRITE] || cmd_q[CMD_ADV])) begin
      addr_d = addr_q + 8'd1;
    end

    if (cmd_q[CMD_WRITE]) begin
      if (w_pt_hit) begin
        if (w_busy) err_d = 1'b1;
        else        pt_d[{addr_q[2:0], 3'b000} +: 8] = in_q;
      end
      if (w_key_hit) begin
        if (w_busy) begin
          err_d = 1'b1;
        end else begin
          for (int n = 0; n < KB; n++) begin
            if (addr_q[3:0] == 4'(n)) key_d[8*n +: 8] = in_q;
          end
        end
      end
      if (w_test_hit) test_d = in_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_q[CMD_START]) begin
          state_d = S_REQ;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_REQ:   if (!Ready_i) state_d = S_RUN;
      S_RUN:   if (Ready_i)  state_d = S_CAP;
      S_CAP: begin
        snap_d  = CipherText_ib;
        cnt_d   = cnt_q + 8'd1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A rejected START always flags, whatever else the command carried.
    if (w_busy && cmd_q[CMD_START]) err_d = 1'b1;
  end

  always_ff @(posedge Clk_ik) begin
    if (Reset_ir) begin
      cmd_q   <= 4'h0;
      in_q    <= 8'h00;
      addr_q  <= 8'h00;
      pt_q    <= '0;
      key_q   <= '0;
      test_q  <= 8'h00;
      snap_q  <= '0;
      cnt_q   <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      cmd_q   <= cmd_d;
      in_q    <= in_d;
      addr_q  <= addr_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      test_q  <= test_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    if (w_pt_hit)                w_rd_data = snap_q[{addr_q[2:0], 3'b000} +: 8];
    else if (w_test_hit)         w_rd_data = test_q;
    else if (addr_q == 8'h20)    w_rd_data = cnt_q;
  end

  assign w_status     = {4'b0000, err_q, w_busy, done_q, Ready_i};
  assign Data_ob      = Addr_ib[1] ? w_rd_data : w_status;
  assign PlainText_ob = pt_q;
  assign Key_ob       = key_q;
  assign Start_o      = (state_q == S_REQ);

endmodule
`default_nettype wire
